// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch history table predictor.
//   - 2-bit counter encoding (strong/weak not-taken, weak/strong taken)
//   - default index width of the table
//   - bp_sat_next(): saturating next value of a counter for a resolved outcome
// Optional feature macro used by the top: BP_GSHARE_EN.
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam logic [1:0] BP_SNT = 2'b00;
    localparam logic [1:0] BP_WNT = 2'b01;
    localparam logic [1:0] BP_WT  = 2'b10;
    localparam logic [1:0] BP_ST  = 2'b11;

    localparam int BP_IDX_BITS_DEF = 4;

    // Move one step toward the resolved direction, clamping at either end.
    function automatic logic [1:0] bp_sat_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == BP_ST) ? BP_ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == BP_SNT) ? BP_SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_counter2.sv
// -----------------------------------------------------------------------------
// bp_counter2
// One 2-bit saturating branch counter of the history table.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (loads CTR_INIT)
//   en_i     in   apply the resolved outcome at this edge
//   taken_i  in   resolved outcome (1 = taken)
//   ctr_o    out  current counter value
// -----------------------------------------------------------------------------
module bp_counter2
    import bp_pkg::*;
#(
    parameter logic [1:0] CTR_INIT = BP_WNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    logic [1:0] ctr_q;
    logic [1:0] ctr_d;

    // Saturating step toward the resolved direction.
    always_comb begin
        ctr_d = bp_sat_next(ctr_q, taken_i);
    end

    // Counter state; only moves when this entry is the one being updated.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q <= CTR_INIT;
        end else if (en_i) begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Branch history table of 2-bit saturating counters for the Y86 fetch stage.
// Fetch reads a combinational prediction for a conditional jump; execute
// writes back the resolved outcome, which lands in the table at the next edge.
// Optional feature: define BP_GSHARE_EN to XOR the index with a global
// history register of the most recent IDX_BITS outcomes (gshare).
// Ports:
//   CLOCK_50        in   system clock, rising edge
//   reset           in   asynchronous active-high reset
//   lookup_valid    in   fetch presents a conditional jump this cycle
//   lookup_pc       in   address of that jump
//   pred_taken      out  prediction for lookup_pc (combinational, 0 if idle)
//   pred_table      out  MSB of every counter, bit i = physical entry i
//   update_valid    in   execute resolved a conditional jump this cycle
//   update_pc       in   address of the resolved jump
//   update_taken    in   actual outcome
//   update_mispred  in   execute flagged a misprediction
//   stat_lookups    out  saturating count of lookup_valid cycles
//   stat_mispreds   out  saturating count of update_valid & update_mispred
// -----------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         IDX_BITS = BP_IDX_BITS_DEF,
    parameter logic [1:0] CTR_INIT = BP_WNT,
    parameter int         STAT_W   = 16,
    localparam int        ENTRIES  = 2 ** IDX_BITS
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              lookup_valid,
    input  logic [31:0]       lookup_pc,
    output logic              pred_taken,
    output logic [ENTRIES-1:0] pred_table,
    input  logic              update_valid,
    input  logic [31:0]       update_pc,
    input  logic              update_taken,
    input  logic              update_mispred,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_mispreds
);

    logic [IDX_BITS-1:0] lkp_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [1:0]          ctr [ENTRIES];

    logic [STAT_W-1:0]   lookups_q;
    logic [STAT_W-1:0]   lookups_d;
    logic [STAT_W-1:0]   mispreds_q;
    logic [STAT_W-1:0]   mispreds_d;

    // Only the low PC bits select an entry; the rest are deliberately ignored
    // (aliasing is accepted, there are no tags).
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[31:IDX_BITS], update_pc[31:IDX_BITS]};

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q;
    logic [IDX_BITS-1:0] ghr_d;

    // Both ports hash with the history as it stands before this edge's shift,
    // so a lookup and an update in the same cycle agree on the index.
    assign lkp_idx = lookup_pc[IDX_BITS-1:0] ^ ghr_q;
    assign upd_idx = update_pc[IDX_BITS-1:0] ^ ghr_q;

    // Shift the newest resolved outcome into the LSB.
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid) begin
            ghr_d = {ghr_q[IDX_BITS-2:0], update_taken};
        end
    end

    // Global history register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign lkp_idx = lookup_pc[IDX_BITS-1:0];
    assign upd_idx = update_pc[IDX_BITS-1:0];
`endif

    // One counter per physical entry; pred_table exposes the direction bit.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        bp_counter2 #(
            .CTR_INIT (CTR_INIT)
        ) u_ctr (
            .clk     (CLOCK_50),
            .rst     (reset),
            .en_i    (update_valid && (upd_idx == IDX_BITS'(i))),
            .taken_i (update_taken),
            .ctr_o   (ctr[i])
        );
        assign pred_table[i] = ctr[i][1];
    end

    // Reads registered state, so a same-cycle update is not bypassed.
    assign pred_taken = lookup_valid & ctr[lkp_idx][1];

    // Statistics hold at all-ones instead of wrapping.
    always_comb begin
        lookups_d  = lookups_q;
        mispreds_d = mispreds_q;
        if (lookup_valid && (lookups_q != '1)) begin
            lookups_d = lookups_q + STAT_W'(1);
        end
        if (update_valid && update_mispred && (mispreds_q != '1)) begin
            mispreds_d = mispreds_q + STAT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lookups_q  <= '0;
            mispreds_q <= '0;
        end else begin
            lookups_q  <= lookups_d;
            mispreds_q <= mispreds_d;
        end
    end

    assign stat_lookups  = lookups_q;
    assign stat_mispreds = mispreds_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Self-checking bench for branch_predictor. Expected values are queued when
// stimulus is applied and compared once the outputs have settled.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int SEL_PRED     = 0;
    localparam int SEL_TABLE    = 1;
    localparam int SEL_LOOKUPS  = 2;
    localparam int SEL_MISPREDS = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sbItem_t;

    logic        CLOCK_50;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        pred_taken;
    logic [15:0] pred_table;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic        update_mispred;
    logic [15:0] stat_lookups;
    logic [15:0] stat_mispreds;

    sbItem_t sbQ[$];
    int      assertCount = 0;
    int      failCount   = 0;
    int      mdlLookups  = 0;
    int      mdlMispreds = 0;

    branch_predictor dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .lookup_valid   (lookup_valid),
        .lookup_pc      (lookup_pc),
        .pred_taken     (pred_taken),
        .pred_table     (pred_table),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_taken   (update_taken),
        .update_mispred (update_mispred),
        .stat_lookups   (stat_lookups),
        .stat_mispreds  (stat_mispreds)
    );

    // 100 MHz-style free-running clock; rising edges at 5, 15, 25, ...
    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic lv, input logic [31:0] lpc, input logic uv,
                                 input logic [31:0] upc, input logic ut, input logic um);
        lookup_valid   = lv;
        lookup_pc      = lpc;
        update_valid   = uv;
        update_pc      = upc;
        update_taken   = ut;
        update_mispred = um;
    endtask

    task automatic expectOut(input string tag, input int sel, input logic [31:0] exp);
        sbItem_t it;
        it.tag = tag;
        it.sel = sel;
        it.exp = exp;
        sbQ.push_back(it);
    endtask

    // Push the statistics the model currently predicts.
    task automatic expectStats(input string tag);
        expectOut({tag, "_lookups"}, SEL_LOOKUPS, 32'(mdlLookups));
        expectOut({tag, "_mispreds"}, SEL_MISPREDS, 32'(mdlMispreds));
    endtask

    // Let combinational outputs settle, then compare every queued expectation.
    task automatic drainScoreboard();
        sbItem_t     it;
        logic [31:0] obs;
        #2;
        while (sbQ.size() > 0) begin
            it = sbQ.pop_front();
            case (it.sel)
                SEL_PRED:    obs = 32'(pred_taken);
                SEL_TABLE:   obs = 32'(pred_table);
                SEL_LOOKUPS: obs = 32'(stat_lookups);
                default:     obs = 32'(stat_mispreds);
            endcase
            checkOutput(it.tag, obs, it.exp);
        end
    endtask

    // Advance one rising edge, updating the statistics model from the inputs
    // that are present at that edge.
    task automatic stepClock();
        if (lookup_valid && mdlLookups < 16'hFFFF) mdlLookups++;
        if (update_valid && update_mispred && mdlMispreds < 16'hFFFF) mdlMispreds++;
        @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 32'h37, 1'b0, 32'h0, 1'b0, 1'b0);

        // Reset state, observed both during and just after reset.
        expectOut("rst_pred", SEL_PRED, 32'h0);
        expectOut("rst_table", SEL_TABLE, 32'h0);
        expectStats("rst");
        drainScoreboard();
        #10;
        reset = 1'b0;
        expectOut("post_rst_pred", SEL_PRED, 32'h0);
        expectOut("post_rst_table", SEL_TABLE, 32'h0);
        expectStats("post_rst");
        drainScoreboard();

`ifndef BP_GSHARE_EN
        // Two taken updates to entry 5: 01 -> 10 -> 11.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h15, 1'b1, 1'b0);
        stepClock();
        expectOut("upd1_table", SEL_TABLE, 32'h0020);
        drainScoreboard();
        stepClock();
        applyStimulus(1'b1, 32'h25, 1'b0, 32'h0, 1'b0, 1'b0);
        expectOut("alias_pred", SEL_PRED, 32'h1);
        expectOut("upd2_table", SEL_TABLE, 32'h0020);
        drainScoreboard();
        stepClock();
        expectStats("alias");
        drainScoreboard();

        // Saturation at strong taken, then walk back down.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h15, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) stepClock();
        applyStimulus(1'b1, 32'h15, 1'b0, 32'h0, 1'b0, 1'b0);
        expectOut("sat_hi_pred", SEL_PRED, 32'h1);
        expectOut("sat_hi_table", SEL_TABLE, 32'h0020);
        drainScoreboard();
        applyStimulus(1'b1, 32'h15, 1'b1, 32'h15, 1'b0, 1'b0);
        stepClock();
        expectOut("wt_pred", SEL_PRED, 32'h1);
        expectOut("wt_table", SEL_TABLE, 32'h0020);
        drainScoreboard();
        stepClock();
        expectOut("wnt_pred", SEL_PRED, 32'h0);
        expectOut("wnt_table", SEL_TABLE, 32'h0000);
        drainScoreboard();

        // Bring entry 5 to 10, then lookup and not-taken update together.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h15, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h15, 1'b1, 32'h15, 1'b0, 1'b0);
        expectOut("same_cyc_pred", SEL_PRED, 32'h1);
        drainScoreboard();
        stepClock();
        applyStimulus(1'b1, 32'h15, 1'b0, 32'h0, 1'b0, 1'b0);
        expectOut("next_cyc_pred", SEL_PRED, 32'h0);
        expectStats("same_cyc");
        drainScoreboard();
`else
        // Gshare: history shifts in a 1, so pc 0x04 maps onto entry 5.
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h00, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h04, 1'b0, 32'h0, 1'b0, 1'b0);
        expectOut("gs_upd0_table", SEL_TABLE, 32'h0001);
        expectOut("gs_lkp4_pred", SEL_PRED, 32'h0);
        drainScoreboard();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h04, 1'b1, 1'b0);
        stepClock();
        applyStimulus(1'b1, 32'h06, 1'b0, 32'h0, 1'b0, 1'b0);
        expectOut("gs_upd4_table", SEL_TABLE, 32'h0021);
        expectOut("gs_lkp6_pred", SEL_PRED, 32'h1);
        drainScoreboard();
`endif

        // Populate entry 3 and the statistics, then pulse reset mid-cycle.
        applyStimulus(1'b1, 32'h0, 1'b1, 32'h03, 1'b1, 1'b1);
        stepClock();
        stepClock();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
`ifndef BP_GSHARE_EN
        expectOut("pre_pulse_table", SEL_TABLE, 32'h0008);
`endif
        expectStats("pre_pulse");
        drainScoreboard();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        mdlLookups  = 0;
        mdlMispreds = 0;
        applyStimulus(1'b1, 32'h03, 1'b0, 32'h0, 1'b0, 1'b0);
        expectOut("pulse_table", SEL_TABLE, 32'h0000);
        expectOut("pulse_pred", SEL_PRED, 32'h0);
        expectStats("pulse");
        drainScoreboard();

        // Mispredict flag without update_valid must be ignored.
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0A, 1'b0, 1'b1);
        stepClock();
        stepClock();
        expectOut("ign_mispreds", SEL_MISPREDS, 32'h0);
        drainScoreboard();
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h0A, 1'b0, 1'b1);
        stepClock();
        expectOut("one_mispred", SEL_MISPREDS, 32'h1);
        drainScoreboard();

        // 0xFFFF + 2 mispredict cycles in total: counter holds at all-ones.
        for (int i = 0; i < 65536; i++) stepClock();
        expectOut("sat_mispreds", SEL_MISPREDS, 32'hFFFF);
        expectStats("sat");
        drainScoreboard();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        stepClock();
        expectOut("sat_hold_mispreds", SEL_MISPREDS, 32'hFFFF);
        drainScoreboard();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
